// File: rtl/min_int32_stream_reduce.sv
`default_nettype none
// ============================================================================
// Module   : min_int32_stream_reduce (with gt_int_nbit and min_int32 datapath)
// Purpose  : Sequential controller that streams LEN signed WIDTH-bit words
//            through one shared min datapath and returns the minimum value
//            together with the index of its first occurrence.
// Ports    : clk, rst_n            - rising-edge clock, async active-low reset
//            start, len            - request a reduction of len words (IDLE only)
//            busy                  - high while accumulating or holding a result
//            in_valid/in_ready     - element stream handshake, in_data payload
//            res_valid/res_ready   - result handshake
//            res_min/res_idx       - minimum value and its first index
//            res_empty             - the reduction had len == 0
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// gt_int_nbit: signed greater-than, a > b, two's complement operands.
// ----------------------------------------------------------------------------
module gt_int_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  generate
    if (IMPL_TYPE == 0) begin : g_signed
      assign gt = $signed(a) > $signed(b);
    end else begin : g_offset
      // Flipping the sign bit maps two's complement onto offset binary,
      // where an unsigned compare gives the signed ordering.
      logic [WIDTH-1:0] a_off;
      logic [WIDTH-1:0] b_off;
      assign a_off = {~a[WIDTH-1], a[WIDTH-2:0]};
      assign b_off = {~b[WIDTH-1], b[WIDTH-2:0]};
      assign gt    = a_off > b_off;
    end
  endgenerate
endmodule

// ----------------------------------------------------------------------------
// min_int32: combinational signed minimum; exposes the compare result so the
// controller can decide whether the index moves.
// ----------------------------------------------------------------------------
module min_int32 #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min_val,
  output logic             a_gt_b
);
  gt_int_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .a  (a),
    .b  (b),
    .gt (a_gt_b)
  );

  // On a tie a is kept, which preserves the earlier index upstream.
  assign min_val = a_gt_b ? b : a;
endmodule

// ----------------------------------------------------------------------------
// min_int32_stream_reduce: top-level controller.
// ----------------------------------------------------------------------------
module min_int32_stream_reduce #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_min,
  output logic [CNT_WIDTH-1:0] res_idx,
  output logic                 res_empty
);

  localparam logic [WIDTH-1:0]     MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] idx;
  logic [WIDTH-1:0]     acc;

  logic [WIDTH-1:0]     min_val;
  logic                 acc_gt_data;
  logic                 xfer;
  logic                 last;

  min_int32 #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_min (
    .a       (acc),
    .b       (in_data),
    .min_val (min_val),
    .a_gt_b  (acc_gt_data)
  );

  // in_ready is high exactly while in ACCUM, so this is the transfer strobe.
  assign xfer = in_valid & in_ready;
  // len_q is never zero in ACCUM, so len_q-1 cannot underflow; comparing
  // against len_q-1 also keeps cnt from wrapping at the maximum length.
  assign last = (cnt == (len_q - CNT_ONE));

  assign res_min = acc;
  assign res_idx = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= CNT_ZERO;
      cnt       <= CNT_ZERO;
      idx       <= CNT_ZERO;
      acc       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            cnt       <= CNT_ZERO;
            idx       <= CNT_ZERO;
            acc       <= MOST_POS;
            res_empty <= (len == CNT_ZERO);
            busy      <= 1'b1;
            if (len == CNT_ZERO) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            acc <= min_val;
            // The first element always claims the index so that data equal
            // to the initial accumulator still reports a real position.
            if ((cnt == CNT_ZERO) || acc_gt_data) begin
              idx <= cnt;
            end
            cnt <= cnt + CNT_ONE;
            if (last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
